// File: rtl/acc_control_fsm.sv
// Multicycle control unit for a 16-bit accumulator CPU: FETCH/DECODE/MEM/WB/BRANCH/HALT.
// Latency: NOP 2+w, LDI/JUMP/BEQZ 3+w, STORE 3+2w, LOAD/ALU 4+2w cycles (w = memory wait cycles).
// Backpressure: FETCH and MEM hold their memory request until MemAck; MemAck elsewhere is ignored.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Opcode, Zero      IR[15:12] (valid from DECODE onward), accumulator-is-zero flag
//   MemAck            one-cycle completion strobe for MemRead/MemWrite
//   MemRead/MemWrite/IorD                 memory request and address select
//   IRWrite/PCWrite/PCSrc                 instruction register and PC control
//   ACCWrite/ACCSrc/ALUOp                 accumulator write, input mux and ALU operation
//   Halted, RetireCount                   HALT indicator, retired-instruction counter
module acc_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Opcode,
    input  logic        Zero,
    input  logic        MemAck,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        ACCWrite,
    output logic [1:0]  ACCSrc,
    output logic [1:0]  ALUOp,
    output logic        Halted,
    output logic [15:0] RetireCount
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_BRANCH = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_LDI   = 4'h6;
    localparam logic [3:0] OP_BEQZ  = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [2:0]  state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] retire_q, retire_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= 4'h0;
            retire_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            retire_q <= retire_d;
        end
    end

    // Next-state logic. DECODE routes on the live Opcode input since the
    // latched copy only becomes valid one cycle later.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH: begin
                if (MemAck) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = Opcode;
                case (Opcode)
                    OP_LOAD, OP_STORE, OP_ADD,
                    OP_SUB, OP_AND, OP_OR:     state_d = S_MEM;
                    OP_LDI:                    state_d = S_WB;
                    OP_BEQZ, OP_JUMP:          state_d = S_BRANCH;
                    OP_HALT:                   state_d = S_HALT;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (MemAck) state_d = (opcode_q == OP_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // An instruction retires whenever control returns to FETCH from any
    // other state; HALT never returns, so it is never counted.
    always_comb begin
        retire_d = retire_q;
        if (state_q != S_FETCH && state_q != S_HALT && state_d == S_FETCH)
            retire_d = retire_q + 16'd1;
    end

    // Output decode. Reset gates every output so the FETCH read request is
    // not visible while reset is held.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        ACCWrite = 1'b0;
        ACCSrc   = 2'd0;
        ALUOp    = 2'd0;
        Halted   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = MemAck;
                    PCWrite = MemAck;
                end
                S_MEM: begin
                    IorD = 1'b1;
                    if (opcode_q == OP_STORE) MemWrite = 1'b1;
                    else                      MemRead  = 1'b1;
                end
                S_WB: begin
                    ACCWrite = 1'b1;
                    case (opcode_q)
                        OP_LOAD: ACCSrc = 2'd1;
                        OP_LDI:  ACCSrc = 2'd2;
                        default: begin
                            ACCSrc = 2'd0;
                            // ADD..OR are opcodes 2..5; low bits minus 2 give 0..3
                            ALUOp  = opcode_q[1:0] - 2'd2;
                        end
                    endcase
                end
                S_BRANCH: begin
                    PCSrc   = 1'b1;
                    PCWrite = (opcode_q == OP_JUMP) ? 1'b1 : Zero;
                end
                S_HALT:   Halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign RetireCount = retire_q;

endmodule

// File: tb/tb_acc_control_fsm.sv
module tb_acc_control_fsm;

    logic        clk;
    logic        reset;
    logic [3:0]  Opcode;
    logic        Zero;
    logic        MemAck;
    logic        MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ACCWrite, Halted;
    logic [1:0]  ACCSrc, ALUOp;
    logic [15:0] RetireCount;

    int errors = 0;
    int checks = 0;

    acc_control_fsm dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemAck(MemAck),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ACCWrite(ACCWrite), .ACCSrc(ACCSrc),
        .ALUOp(ALUOp), .Halted(Halted), .RetireCount(RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ACCWrite, ACCSrc, ALUOp, Halted}
    logic [11:0] outs;
    assign outs = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
                   ACCWrite, ACCSrc, ALUOp, Halted};

    localparam logic [11:0] NONE    = 12'h000;
    localparam logic [11:0] F_WAIT  = 12'h800; // MemRead, IorD=0
    localparam logic [11:0] F_ACK   = 12'h980; // MemRead + IRWrite + PCWrite, PCSrc=0
    localparam logic [11:0] DEC     = 12'h000;
    localparam logic [11:0] MEM_RD  = 12'hA00; // MemRead + IorD
    localparam logic [11:0] MEM_WR  = 12'h600; // MemWrite + IorD
    localparam logic [11:0] WB_LDI  = 12'h030; // ACCWrite, ACCSrc=2
    localparam logic [11:0] WB_LOAD = 12'h028; // ACCWrite, ACCSrc=1
    localparam logic [11:0] WB_ADD  = 12'h020; // ACCWrite, ACCSrc=0, ALUOp=0
    localparam logic [11:0] WB_SUB  = 12'h022; // ALUOp=1
    localparam logic [11:0] WB_OR   = 12'h026; // ALUOp=3
    localparam logic [11:0] BR_T    = 12'h0C0; // PCSrc + PCWrite
    localparam logic [11:0] BR_F    = 12'h040; // PCSrc only
    localparam logic [11:0] HALT_E  = 12'h001;

    // Advance one clock, drive inputs just after the edge, return at the
    // following falling edge where outputs are sampled.
    task automatic step(input logic [3:0] op, input logic ack, input logic z);
        @(posedge clk);
        #1;
        Opcode = op;
        MemAck = ack;
        Zero   = z;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        MemAck = 1'b0;
        Zero   = 1'b0;
        Opcode = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        MemAck = 1'b1;
        Opcode = 4'h2;
        #1;
        checks++;
        if (outs !== NONE) begin
            errors++;
            $display("FAIL reset_outs: got %h expected %h", outs, NONE);
        end
        checks++;
        if (RetireCount !== 16'h0000) begin
            errors++;
            $display("FAIL reset_retire: got %h expected 0000", RetireCount);
        end
        @(posedge clk);
        #1;
        MemAck = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== F_WAIT) begin
            errors++;
            $display("FAIL reset_first_fetch: got %h expected %h", outs, F_WAIT);
        end
    endtask

    // LDI (immediate 5) then ADD (memory word 7), MemAck in the request cycle.
    task automatic test_ldi_add();
        logic [17:0] t [8];
        t = '{ {4'h6,1'b1,1'b0,F_ACK}, {4'h6,1'b0,1'b0,DEC}, {4'h6,1'b0,1'b0,WB_LDI},
               {4'h2,1'b1,1'b0,F_ACK}, {4'h2,1'b0,1'b0,DEC}, {4'h2,1'b1,1'b0,MEM_RD},
               {4'h2,1'b0,1'b0,WB_ADD}, {4'h0,1'b0,1'b0,F_WAIT} };
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(t[i][17:14], t[i][13], t[i][12]);
            checks++;
            if (outs !== t[i][11:0]) begin
                errors++;
                $display("FAIL ldi_add cycle %0d: got %h expected %h", i + 1, outs, t[i][11:0]);
            end
        end
        checks++;
        if (RetireCount !== 16'd2) begin
            errors++;
            $display("FAIL ldi_add_retire: got %0d expected 2", RetireCount);
        end
    endtask

    // Three wait cycles in FETCH, then a NOP (opcode A) retires.
    task automatic test_memack_wait();
        logic [17:0] t [6];
        t = '{ {4'hA,1'b0,1'b0,F_WAIT}, {4'hA,1'b0,1'b0,F_WAIT}, {4'hA,1'b0,1'b0,F_WAIT},
               {4'hA,1'b1,1'b0,F_ACK},  {4'hA,1'b0,1'b0,DEC},    {4'hA,1'b0,1'b0,F_WAIT} };
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(t[i][17:14], t[i][13], t[i][12]);
            checks++;
            if (outs !== t[i][11:0]) begin
                errors++;
                $display("FAIL memack_wait cycle %0d: got %h expected %h", i, outs, t[i][11:0]);
            end
        end
        checks++;
        if (RetireCount !== 16'd1) begin
            errors++;
            $display("FAIL memack_wait_retire: got %0d expected 1", RetireCount);
        end
    endtask

    // BEQZ taken, BEQZ not taken, JUMP with Zero low.
    task automatic test_beqz();
        logic [17:0] t [10];
        t = '{ {4'h7,1'b1,1'b0,F_ACK}, {4'h7,1'b0,1'b0,DEC}, {4'h7,1'b0,1'b1,BR_T},
               {4'h7,1'b1,1'b0,F_ACK}, {4'h7,1'b0,1'b0,DEC}, {4'h7,1'b0,1'b0,BR_F},
               {4'h8,1'b1,1'b0,F_ACK}, {4'h8,1'b0,1'b0,DEC}, {4'h8,1'b0,1'b0,BR_T},
               {4'h0,1'b0,1'b0,F_WAIT} };
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(t[i][17:14], t[i][13], t[i][12]);
            checks++;
            if (outs !== t[i][11:0]) begin
                errors++;
                $display("FAIL beqz cycle %0d: got %h expected %h", i, outs, t[i][11:0]);
            end
        end
        checks++;
        if (RetireCount !== 16'd3) begin
            errors++;
            $display("FAIL beqz_retire: got %0d expected 3", RetireCount);
        end
    endtask

    // STORE with two MEM wait cycles; MemAck in DECODE must be ignored.
    task automatic test_store();
        logic [17:0] t [6];
        t = '{ {4'h1,1'b1,1'b0,F_ACK},  {4'h1,1'b1,1'b0,DEC},    {4'h1,1'b0,1'b0,MEM_WR},
               {4'h1,1'b0,1'b0,MEM_WR}, {4'h1,1'b1,1'b0,MEM_WR}, {4'h1,1'b0,1'b0,F_WAIT} };
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(t[i][17:14], t[i][13], t[i][12]);
            checks++;
            if (outs !== t[i][11:0]) begin
                errors++;
                $display("FAIL store cycle %0d: got %h expected %h", i, outs, t[i][11:0]);
            end
        end
        checks++;
        if (RetireCount !== 16'd1) begin
            errors++;
            $display("FAIL store_retire: got %0d expected 1", RetireCount);
        end
    endtask

    // LOAD, SUB (one MEM wait) and OR; MemAck during WB is ignored.
    task automatic test_alu_ops();
        logic [17:0] t [14];
        t = '{ {4'h0,1'b1,1'b0,F_ACK}, {4'h0,1'b0,1'b0,DEC}, {4'h0,1'b1,1'b0,MEM_RD},
               {4'h0,1'b1,1'b0,WB_LOAD},
               {4'h3,1'b1,1'b0,F_ACK}, {4'h3,1'b0,1'b0,DEC}, {4'h3,1'b0,1'b0,MEM_RD},
               {4'h3,1'b1,1'b0,MEM_RD}, {4'h3,1'b0,1'b0,WB_SUB},
               {4'h5,1'b1,1'b0,F_ACK}, {4'h5,1'b0,1'b0,DEC}, {4'h5,1'b1,1'b0,MEM_RD},
               {4'h5,1'b0,1'b0,WB_OR}, {4'h4,1'b0,1'b0,F_WAIT} };
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(t[i][17:14], t[i][13], t[i][12]);
            checks++;
            if (outs !== t[i][11:0]) begin
                errors++;
                $display("FAIL alu_ops cycle %0d: got %h expected %h", i, outs, t[i][11:0]);
            end
        end
        checks++;
        if (RetireCount !== 16'd3) begin
            errors++;
            $display("FAIL alu_ops_retire: got %0d expected 3", RetireCount);
        end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        step(4'hF, 1'b1, 1'b0);
        checks++;
        if (outs !== F_ACK) begin
            errors++;
            $display("FAIL halt_fetch: got %h expected %h", outs, F_ACK);
        end
        step(4'hF, 1'b0, 1'b0);
        checks++;
        if (outs !== DEC) begin
            errors++;
            $display("FAIL halt_decode: got %h expected %h", outs, DEC);
        end
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            step(4'(i), 1'(i), 1'b1);
            if (outs !== HALT_E) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold: %0d of 22 cycles wrong, last got %h expected %h", bad, outs, HALT_E);
        end
        checks++;
        if (RetireCount !== 16'd0) begin
            errors++;
            $display("FAIL halt_retire: got %0d expected 0", RetireCount);
        end
        do_reset();
        checks++;
        if (outs !== F_WAIT) begin
            errors++;
            $display("FAIL halt_exit: got %h expected %h", outs, F_WAIT);
        end
        step(4'hA, 1'b1, 1'b0);
        checks++;
        if (outs !== F_ACK) begin
            errors++;
            $display("FAIL halt_resume: got %h expected %h", outs, F_ACK);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        step(4'h2, 1'b1, 1'b0);
        step(4'h2, 1'b0, 1'b0);
        step(4'h2, 1'b0, 1'b0);
        checks++;
        if (outs !== MEM_RD) begin
            errors++;
            $display("FAIL midmem_in_mem: got %h expected %h", outs, MEM_RD);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== NONE) begin
            errors++;
            $display("FAIL midmem_immediate: got %h expected %h", outs, NONE);
        end
        MemAck = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== NONE) begin
            errors++;
            $display("FAIL midmem_held: got %h expected %h", outs, NONE);
        end
        reset  = 1'b0;
        MemAck = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== F_WAIT) begin
            errors++;
            $display("FAIL midmem_refetch: got %h expected %h", outs, F_WAIT);
        end
        checks++;
        if (RetireCount !== 16'd0) begin
            errors++;
            $display("FAIL midmem_retire: got %0d expected 0", RetireCount);
        end
    endtask

    // Counter preloaded close to the top stands in for 65533 earlier NOPs;
    // three more NOPs carry it through FFFF to 0000.
    task automatic test_wrap();
        logic [15:0] exp_cnt [3];
        exp_cnt = '{16'hFFFE, 16'hFFFF, 16'h0000};
        do_reset();
        force dut.retire_q = 16'hFFFD;
        #1;
        release dut.retire_q;
        for (int i = 0; i < 3; i++) begin
            step(4'hA, 1'b1, 1'b0);
            step(4'hA, 1'b0, 1'b0);
            step(4'hA, 1'b0, 1'b0);
            checks++;
            if (RetireCount !== exp_cnt[i]) begin
                errors++;
                $display("FAIL wrap nop %0d: got %h expected %h", i, RetireCount, exp_cnt[i]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        Opcode = 4'h0;
        Zero   = 1'b0;
        MemAck = 1'b0;
        test_reset();
        test_ldi_add();
        test_memack_wait();
        test_beqz();
        test_store();
        test_alu_ops();
        test_halt();
        test_reset_mid_mem();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
